// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared constants and geometry helpers for the direct-mapped data cache
package dcache_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFFW           = 2;
    localparam int LINE_BYTE_BITS = OFFW + 2;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int width, input int lines);
        return width - LINE_BYTE_BITS - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_ram.sv
// rtl/dcache_ram.sv - cache data and tag arrays, asynchronous read, one synchronous word write
module dcache_ram import dcache_pkg::*; #(
    parameter int LINES = 16,
    parameter int IDXW  = 4,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [OFFW-1:0] rd_off,
    output logic [31:0]     rd_data,
    output logic [TAGW-1:0] rd_tag,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [OFFW-1:0] wr_off,
    input  logic [31:0]     wr_data,
    input  logic            tag_we,
    input  logic [TAGW-1:0] tag_wdata
);

    logic [31:0]     data_q [0:LINES*WORDS_PER_LINE-1];
    logic [TAGW-1:0] tag_q  [0:LINES-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_idx, wr_off}] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_idx] <= tag_wdata;
        end
    end

    assign rd_data = data_q[{rd_idx, rd_off}];
    assign rd_tag  = tag_q[rd_idx];

endmodule

// File: rtl/dcache_m.sv
// rtl/dcache_m.sv - direct-mapped write-through no-write-allocate data cache with 4-word line refill
module dcache_m import dcache_pkg::*; #(
    parameter int WIDTH = 12,
    parameter int LINES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_stall,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic             i_mem_ready,
    input  logic [31:0]      i_mem_rdata
);

    localparam int IDXW = idx_width(LINES);
    localparam int TAGW = tag_width(WIDTH, LINES);

    logic [1:0]       state;
    logic [OFFW-1:0]  cnt;
    logic [WIDTH-5:0] line_q;
    logic [WIDTH-3:0] st_word;
    logic [31:0]      st_data;
    logic [LINES-1:0] valid;

    logic [WIDTH-3:0] look_word;
    logic [OFFW-1:0]  look_off;
    logic [IDXW-1:0]  look_idx;
    logic [TAGW-1:0]  look_tag;
    logic [31:0]      ram_rdata;
    logic [TAGW-1:0]  ram_tag;
    logic             hit;

    logic             ram_we;
    logic             tag_we;
    logic [IDXW-1:0]  wr_idx;
    logic [OFFW-1:0]  wr_off;
    logic [31:0]      ram_wdata;
    logic             unused_bits;

    assign unused_bits = &{1'b0, i_addr[1:0]};

    // During WRITE the lookup follows the latched store so the hit test is independent of the core bus
    assign look_word = (state == ST_WRITE) ? st_word : i_addr[WIDTH-1:2];
    assign look_off  = look_word[OFFW-1:0];
    assign look_idx  = look_word[OFFW +: IDXW];
    assign look_tag  = look_word[OFFW+IDXW +: TAGW];
    assign hit       = valid[look_idx] && (ram_tag == look_tag);

    dcache_ram #(
        .LINES (LINES),
        .IDXW  (IDXW),
        .TAGW  (TAGW)
    ) u_ram (
        .clk       (i_clk),
        .rd_idx    (look_idx),
        .rd_off    (look_off),
        .rd_data   (ram_rdata),
        .rd_tag    (ram_tag),
        .wr_en     (ram_we),
        .wr_idx    (wr_idx),
        .wr_off    (wr_off),
        .wr_data   (ram_wdata),
        .tag_we    (tag_we),
        .tag_wdata (line_q[IDXW +: TAGW])
    );

    // Reset gates every array write so an interrupted refill or store leaves the cache untouched
    always_comb begin
        ram_we    = 1'b0;
        tag_we    = 1'b0;
        wr_idx    = line_q[IDXW-1:0];
        wr_off    = cnt;
        ram_wdata = i_mem_rdata;
        if (!i_rst && i_mem_ready) begin
            if (state == ST_REFILL) begin
                ram_we = 1'b1;
                tag_we = &cnt;
            end else if (state == ST_WRITE) begin
                ram_we    = hit;
                wr_idx    = st_word[OFFW +: IDXW];
                wr_off    = st_word[OFFW-1:0];
                ram_wdata = st_data;
            end
        end
    end

    always_comb begin
        o_stall     = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                o_stall = i_req && (i_we || !hit);
            end
            ST_REFILL: begin
                o_stall    = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = {line_q, cnt, 2'b00};
            end
            ST_WRITE: begin
                o_stall     = !i_mem_ready;
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {st_word, 2'b00};
                o_mem_wdata = st_data;
            end
            default: begin
                o_stall = 1'b0;
            end
        endcase
    end

    assign o_rdata = (state == ST_IDLE && i_req && !i_we && hit) ? ram_rdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            valid   <= '0;
            cnt     <= '0;
            line_q  <= '0;
            st_word <= '0;
            st_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        if (i_we) begin
                            st_word <= i_addr[WIDTH-1:2];
                            st_data <= i_wdata;
                            state   <= ST_WRITE;
                        end else if (!hit) begin
                            line_q          <= i_addr[WIDTH-1:4];
                            cnt             <= '0;
                            valid[look_idx] <= 1'b0;
                            state           <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (i_mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            valid[line_q[IDXW-1:0]] <= 1'b1;
                            state                   <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_m.sv
// tb/tb_dcache_m.sv - directed table-driven bench for dcache_m with a word-wide memory model
module tb_dcache_m;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        i_we;
    logic [11:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [11:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int passes = 0;

    int          mem_delay = 0;
    int          wait_cnt = 0;
    logic        mem_init;
    logic [31:0] mem [0:1023];
    logic [11:0] beats [$];

    always #5 i_clk = ~i_clk;

    dcache_m #(.WIDTH(12), .LINES(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_stall     (o_stall),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata)
    );

    // Memory answers after mem_delay waiting cycles; default contents are 0x1000_0000 + byte address
    assign i_mem_ready = o_mem_req && (wait_cnt >= mem_delay);
    assign i_mem_rdata = mem[o_mem_addr[11:2]];

    always @(posedge i_clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'h1000_0000 + 32'(k) * 32'd4;
        end else if (o_mem_req && o_mem_we && i_mem_ready && !i_rst) begin
            mem[o_mem_addr[11:2]] <= o_mem_wdata;
        end
        if (o_mem_req && !o_mem_we && i_mem_ready && !i_rst) beats.push_back(o_mem_addr);
        if (!o_mem_req || i_mem_ready || i_rst) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic        pend_q = 1'b0;
    logic [11:0] pa_q;
    logic [31:0] pd_q;
    logic        pw_q;

    always @(negedge i_clk) begin
        if (pend_q) begin
            check("mem_hold_addr", 32'(o_mem_addr), 32'(pa_q));
            check("mem_hold_wdata", o_mem_wdata, pd_q);
            check("mem_hold_we", 32'(o_mem_we), 32'(pw_q));
        end
        pend_q <= o_mem_req && !i_mem_ready && !i_rst;
        pa_q   <= o_mem_addr;
        pd_q   <= o_mem_wdata;
        pw_q   <= o_mem_we;
    end

    task automatic access(input string name, input logic we, input logic [11:0] addr,
                          input logic [31:0] wd, input int dly, input int exp_stall,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int          stalls;
        logic [31:0] rd;
        logic        mreq;
        stalls    = 0;
        mem_delay = dly;
        i_req     = 1'b1;
        i_we      = we;
        i_addr    = addr;
        i_wdata   = wd;
        @(negedge i_clk);
        while (o_stall && stalls < 100) begin
            stalls++;
            @(negedge i_clk);
        end
        rd   = o_rdata;
        mreq = o_mem_req;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        i_we  = 1'b0;
        check({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
        if (chk_rd) begin
            check({name, "_rdata"}, rd, exp_rd);
            check({name, "_mem_req"}, 32'(mreq), 32'd0);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wd;
        int          dly;
        int          stall;
        logic        chk;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{"hit_108",   1'b0, 12'h108, 32'h0,         0, 0,  1'b1, 32'h1000_0108};
        vecs[1]  = '{"hit_10c",   1'b0, 12'h10C, 32'h0,         0, 0,  1'b1, 32'h1000_010C};
        vecs[2]  = '{"st_104",    1'b1, 12'h104, 32'hDEADBEEF,  3, 4,  1'b0, 32'h0};
        vecs[3]  = '{"hit_104",   1'b0, 12'h104, 32'h0,         0, 0,  1'b1, 32'hDEADBEEF};
        vecs[4]  = '{"st_200",    1'b1, 12'h200, 32'h1234_5678, 0, 1,  1'b0, 32'h0};
        vecs[5]  = '{"miss_200",  1'b0, 12'h200, 32'h0,         0, 5,  1'b1, 32'h1234_5678};
        vecs[6]  = '{"hit_204",   1'b0, 12'h204, 32'h0,         0, 0,  1'b1, 32'h1000_0204};
        vecs[7]  = '{"miss_100b", 1'b0, 12'h100, 32'h0,         0, 5,  1'b1, 32'h1000_0100};
        vecs[8]  = '{"hit_104b",  1'b0, 12'h104, 32'h0,         0, 0,  1'b1, 32'hDEADBEEF};
        vecs[9]  = '{"miss_900",  1'b0, 12'h900, 32'h0,         0, 5,  1'b1, 32'h1000_0900};
        vecs[10] = '{"evict_100", 1'b0, 12'h100, 32'h0,         0, 5,  1'b1, 32'h1000_0100};
        vecs[11] = '{"miss_134",  1'b0, 12'h134, 32'h0,         0, 5,  1'b1, 32'h1000_0134};
        vecs[12] = '{"st_138",    1'b1, 12'h138, 32'hAABB_CCDD, 1, 2,  1'b0, 32'h0};
        vecs[13] = '{"slow_1f0",  1'b0, 12'h1F0, 32'h0,         2, 13, 1'b1, 32'h1000_01F0};

        i_rst    = 1'b1;
        i_req    = 1'b0;
        i_we     = 1'b0;
        i_addr   = '0;
        i_wdata  = '0;
        mem_init = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        mem_init = 1'b0;
        i_rst    = 1'b0;
        @(negedge i_clk);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_we", 32'(o_mem_we), 32'd0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        @(posedge i_clk);
        #1;

        beats.delete();
        access("miss_100", 1'b0, 12'h100, 32'h0, 0, 5, 1'b1, 32'h1000_0100);
        check("beat_count", 32'(beats.size()), 32'd4);
        for (int b = 0; b < 4 && b < beats.size(); b++)
            check($sformatf("beat%0d_addr", b), 32'(beats[b]), 32'h100 + 32'(b) * 32'd4);

        for (int v = 0; v < 14; v++)
            access(vecs[v].name, vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].dly,
                   vecs[v].stall, vecs[v].chk, vecs[v].rd);
        check("st_138_mem", mem[12'h138 >> 2], 32'hAABB_CCDD);
        access("hit_138", 1'b0, 12'h138, 32'h0, 0, 0, 1'b1, 32'hAABB_CCDD);

        beats.delete();
        mem_delay = 0;
        i_req     = 1'b1;
        i_we      = 1'b0;
        i_addr    = 12'h240;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        i_req = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rstref_mem_req", 32'(o_mem_req), 32'd0);
        check("rstref_stall", 32'(o_stall), 32'd0);
        check("rstref_beats", 32'(beats.size()), 32'd2);
        @(posedge i_clk);
        #1;
        access("reload_240", 1'b0, 12'h240, 32'h0, 0, 5, 1'b1, 32'h1000_0240);
        access("post_rst_104", 1'b0, 12'h104, 32'h0, 0, 5, 1'b1, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
